// File: rtl/spi_controller.sv
// CPU-visible SPI master (mode 0, MSB first) for the SD card and RTC.
// Bus writes commit on the phi2 falling edge seen in the clk domain; SCK comes from a clk divider.
module spi_controller #(
   parameter int FAST_HALF = 4,
   parameter int SLOW_HALF = 42
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       phi2,
   input  logic       cs_n,
   input  logic       write_enable,
   input  logic       address,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       spi_clk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_sdcard_cs,
   output logic       spi_rtc_cs
);
   localparam int CW = $clog2((SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF) + 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t        state_q, state_d;
   logic          phi2_q, cs_n_q, we_q, addr_q;
   logic [7:0]    din_q;
   logic [2:0]    ctrl_q, ctrl_d;
   logic [7:0]    rx_q, rx_d, shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d, half_m1;
   logic [3:0]    edge_q, edge_d;
   logic          slow_q, slow_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic          commit, tick, busy;

   assign busy    = (state_q == XFER);
   assign commit  = phi2_q & ~phi2 & ~cs_n_q & we_q;
   assign half_m1 = slow_q ? CW'(SLOW_HALF - 1) : CW'(FAST_HALF - 1);
   assign tick    = (cnt_q == half_m1);

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      rx_d    = rx_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      slow_d  = slow_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      case (state_q)
         IDLE: begin
            // Every commit while busy is dropped, so CTRL only moves here.
            if (commit) begin
               if (!addr_q) begin
                  shift_d = din_q;
                  mosi_d  = din_q[7];
                  cnt_d   = '0;
                  edge_d  = 4'd0;
                  slow_d  = ctrl_q[2];
                  state_d = XFER;
               end else begin
                  ctrl_d = din_q[2:0];
               end
            end
         end
         XFER: begin
            if (tick) begin
               cnt_d  = '0;
               edge_d = edge_q + 4'd1;
               if (edge_q == 4'd15) begin
                  sclk_d  = 1'b0;
                  rx_d    = shift_q;
                  mosi_d  = 1'b1;
                  state_d = IDLE;
               end else if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  shift_d = {shift_q[6:0], spi_miso};
               end else begin
                  sclk_d = 1'b0;
                  mosi_d = shift_q[7];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phi2_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= 1'b0;
         din_q   <= 8'h00;
         state_q <= IDLE;
         ctrl_q  <= 3'b000;
         rx_q    <= 8'h00;
         shift_q <= 8'h00;
         cnt_q   <= '0;
         edge_q  <= 4'd0;
         slow_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b1;
      end else begin
         phi2_q  <= phi2;
         cs_n_q  <= cs_n;
         we_q    <= write_enable;
         addr_q  <= address;
         din_q   <= data_in;
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         rx_q    <= rx_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         slow_q  <= slow_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   always_comb begin
      data_out = 8'h00;
      if (!cs_n) data_out = address ? {busy, 4'b0000, ctrl_q} : rx_q;
   end

   assign spi_clk       = sclk_q;
   assign spi_mosi      = mosi_q;
   assign spi_sdcard_cs = ~ctrl_q[0];
   assign spi_rtc_cs    = ~(ctrl_q[1] & ~ctrl_q[0]);
endmodule
